// File: rtl/instruction_encode.sv
// instruction_encode: encodes RV32I field sets into instruction words, buffered in a 2-entry FIFO with byte addresses
// Ports: clk/rst (sync, active-high); in_valid/in_ready with opcode, rd, rs1, rs2, funct3, funct7, imm;
//        out_valid/out_ready with out_instr (FIFO head) and out_addr (address counter); err_bad_opcode (sticky).
module instruction_encode #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_bad_opcode
);
    logic [31:0] enc;
    logic        bad;
    logic [31:0] mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [31:0] addr_q;
    logic [31:0] addr_d;
    logic        err_q;
    logic        err_d;
    logic        push;
    logic        pop;

    always_comb begin
        enc = 32'h0000_0013;
        bad = 1'b0;
        case (opcode)
            7'b0110011: enc = {funct7, rs2, rs1, funct3, rd, opcode};
            7'b0010011: enc = (funct3 == 3'b001 || funct3 == 3'b101) ? {funct7, imm[4:0], rs1, funct3, rd, opcode}
                                                                      : {imm[11:0], rs1, funct3, rd, opcode};
            7'b0000011, 7'b1100111: enc = {imm[11:0], rs1, funct3, rd, opcode};
            7'b0100011: enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            7'b1100011: enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            7'b0110111, 7'b0010111: enc = {imm[31:12], rd, opcode};
            7'b1101111: enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: bad = 1'b1;
        endcase
    end

    assign in_ready       = cnt_q != 2'd2;
    assign out_valid      = cnt_q != 2'd0;
    assign out_instr      = mem_q[rd_ptr_q];
    assign out_addr       = addr_q;
    assign err_bad_opcode = err_q;
    assign push           = in_valid && in_ready;
    assign pop            = out_valid && out_ready;
    assign cnt_d          = cnt_q + 2'(push) - 2'(pop);
    assign addr_d         = pop ? addr_q + 32'd4 : addr_q;
    assign err_d          = err_q || (push && bad);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= BASE_ADDR;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= enc;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_instruction_encode.sv
// tb_instruction_encode: randomized and directed checks of instruction_encode against a queue-based reference model
module tb_instruction_encode;
    localparam logic [31:0] WBASE = 32'hFFFF_FFF8;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        in_ready, out_valid, err_bad_opcode;
    logic [31:0] out_instr, out_addr;
    logic        w_in_ready, w_out_valid, w_err;
    logic [31:0] w_instr, w_addr;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_q[$];
    logic [31:0] m_addr;
    logic        m_err;
    logic [6:0]  ops [9] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};

    instruction_encode dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .err_bad_opcode(err_bad_opcode)
    );

    instruction_encode #(.BASE_ADDR(WBASE)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_instr(w_instr), .out_addr(w_addr),
        .err_bad_opcode(w_err)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                            input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                            input logic [31:0] im);
        logic [31:0] lo, srcs, w;
        logic        b;
        lo   = (32'(d) << 7) | 32'(op);
        srcs = (32'(s2) << 20) | (32'(s1) << 15) | (32'(f3) << 12);
        b    = 1'b0;
        case (op)
            7'h33: w = (32'(f7) << 25) | srcs | lo;
            7'h13: w = (f3 == 3'd1 || f3 == 3'd5)
                       ? (32'(f7) << 25) | (32'(im[4:0]) << 20) | (32'(s1) << 15) | (32'(f3) << 12) | lo
                       : (im << 20) | (32'(s1) << 15) | (32'(f3) << 12) | lo;
            7'h03, 7'h67: w = (im << 20) | (32'(s1) << 15) | (32'(f3) << 12) | lo;
            7'h23: w = (32'(im[11:5]) << 25) | srcs | (32'(im[4:0]) << 7) | 32'(op);
            7'h63: w = (32'(im[12]) << 31) | (32'(im[10:5]) << 25) | srcs | (32'(im[4:1]) << 8)
                       | (32'(im[11]) << 7) | 32'(op);
            7'h37, 7'h17: w = (im & 32'hFFFF_F000) | lo;
            7'h6F: w = (32'(im[20]) << 31) | (32'(im[10:1]) << 21) | (32'(im[11]) << 20)
                       | (32'(im[19:12]) << 12) | lo;
            default: begin w = 32'h0000_0013; b = 1'b1; end
        endcase
        return {b, w};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        push, pop;
        logic [32:0] e;
        push = in_valid && m_q.size() < 2;
        pop  = out_ready && m_q.size() > 0;
        e    = ref_enc(opcode, rd, rs1, rs2, funct3, funct7, imm);
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            m_addr = 32'd0;
            m_err  = 1'b0;
        end else begin
            if (pop) begin
                void'(m_q.pop_front());
                m_addr += 32'd4;
            end
            if (push) begin
                m_q.push_back(e[31:0]);
                m_err = m_err | e[32];
            end
        end
        check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(m_q.size() < 2));
        check("out_addr", out_addr, m_addr);
        check("err", 32'(err_bad_opcode), 32'(m_err));
        check("wrap_addr", w_addr, m_addr + WBASE);
        if (m_q.size() != 0) check("out_instr", out_instr, m_q[0]);
    endtask

    task automatic set_f(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        m_addr = 32'd0;
        m_err  = 1'b0;
        set_f(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_instr", out_instr, 32'h0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_addr", out_addr, 32'h0);

        set_f(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("add_instr", out_instr, 32'h0020_81B3);
        check("add_addr", out_addr, 32'h0);

        do_reset();
        set_f(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        in_valid = 1'b1;
        step();
        set_f(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        step();
        in_valid = 1'b0;
        check("addi_instr", out_instr, 32'hFFF0_0093);
        check("addi_addr", out_addr, 32'h0);
        out_ready = 1'b1;
        step();
        check("lui_instr", out_instr, 32'h1234_52B7);
        check("lui_addr", out_addr, 32'h4);
        step();
        out_ready = 1'b0;

        do_reset();
        set_f(7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8);
        in_valid = 1'b1;
        step();
        check("beq_instr", out_instr, 32'h0020_8463);
        set_f(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        out_ready = 1'b1;
        step();
        check("jal_instr", out_instr, 32'h0010_00EF);
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;

        do_reset();
        in_valid = 1'b1;
        set_f(7'h33, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step();
        check("fill1_ready", 32'(in_ready), 32'd1);
        set_f(7'h33, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step();
        check("fill2_ready", 32'(in_ready), 32'd0);
        set_f(7'h33, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        step();
        check("held_ready", 32'(in_ready), 32'd0);
        check("drain0_addr", out_addr, 32'h0);
        check("drain0_instr", out_instr, 32'h0000_00B3);
        out_ready = 1'b1;
        step();
        check("drain4_addr", out_addr, 32'h4);
        check("drain4_instr", out_instr, 32'h0000_0133);
        step();
        check("drain8_addr", out_addr, 32'h8);
        check("drain8_instr", out_instr, 32'h0000_01B3);
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;

        do_reset();
        set_f(7'h7F, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'hFFFF_FFFF);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("bad_instr", out_instr, 32'h0000_0013);
        check("bad_err", 32'(err_bad_opcode), 32'd1);
        out_ready = 1'b1;
        repeat (3) step();
        check("bad_sticky", 32'(err_bad_opcode), 32'd1);
        do_reset();
        check("bad_cleared", 32'(err_bad_opcode), 32'd0);

        set_f(7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1;
        step();
        step();
        rst = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_addr", out_addr, 32'h0);
        check("midrst_waddr", w_addr, WBASE);

        for (int i = 0; i < 400; i++) begin
            int k;
            k = $urandom_range(0, 9);
            set_f(k == 9 ? 7'($urandom) : ops[k], 5'($urandom), 5'($urandom), 5'($urandom),
                  3'($urandom), 7'($urandom), $urandom);
            rst       = $urandom_range(0, 49) == 0;
            in_valid  = $urandom_range(0, 2) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
